// File: rtl/port_b_write_queue_if.sv
// Port-B beat bus: upstream beats from the switch into the queue and the
// drained head towards the port-B slave.
interface port_b_write_queue_if;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
  logic        out_ready;

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/port_b_write_queue.sv
// Port-B write queue: address-window filter in front of a circular FIFO with
// overflow/drop status. Define PORT_B_WQ_BYPASS_EN for the empty-queue bypass path.
module port_b_write_queue #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ADDR_BASE = 8'h40
) (
  input  logic                   clk,
  input  logic                   reset,
  port_b_write_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [7:0]             drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    addr_mem_r [DEPTH];
  logic [15:0]   data_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic [7:0]    drop_cnt_r;

  logic addr_ok_s, full_s, empty_s, accept_s, filter_s, discard_s;
  logic bypass_s, push_s, pop_s;

  // Beat classification and push/pop decisions.
  always_comb begin
    addr_ok_s = (bus.in_addr >= ADDR_BASE);
    full_s    = (count_r == FULL_CNT);
    empty_s   = (count_r == {CW{1'b0}});
    accept_s  = bus.in_valid & addr_ok_s & ~full_s;
    filter_s  = bus.in_valid & ~addr_ok_s;
    discard_s = bus.in_valid & addr_ok_s & full_s;
    pop_s     = ~empty_s & bus.out_ready;
`ifdef PORT_B_WQ_BYPASS_EN
    // A beat consumed straight through an empty queue never touches storage.
    bypass_s  = empty_s & accept_s & bus.out_ready;
`else
    bypass_s  = 1'b0;
`endif
    push_s    = accept_s & ~bypass_s;
  end

  // Storage, pointers and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 8'h00;
        data_mem_r[i] <= 16'h0000;
      end
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= bus.in_addr;
        data_mem_r[wr_ptr_r] <= bus.in_data;
        wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      // A new discard outranks a clear arriving in the same cycle.
      if (discard_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
      if (filter_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'h01;
      end
    end
  end

  // Output drive: head entry, or the incoming beat when bypassing.
  always_comb begin
    bus.in_ready  = ~full_s;
    count         = count_r;
    overflow      = overflow_r;
    drop_cnt      = drop_cnt_r;
    bus.out_valid = ~empty_s;
    bus.out_addr  = addr_mem_r[rd_ptr_r];
    bus.out_data  = data_mem_r[rd_ptr_r];
`ifdef PORT_B_WQ_BYPASS_EN
    if (empty_s && accept_s) begin
      bus.out_valid = 1'b1;
      bus.out_addr  = bus.in_addr;
      bus.out_data  = bus.in_data;
    end else begin
      bus.out_valid = ~empty_s;
    end
`endif
  end
endmodule

// File: tb/tb_port_b_write_queue.sv
// Directed bench for port_b_write_queue (DEPTH=4, ADDR_BASE=8'h40): vector table
// plus hand-written sequences for overflow-while-popping, streaming, filtering and wrap.
module tb_port_b_write_queue;
  logic       clk;
  logic       reset;
  logic       clr_overflow;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  port_b_write_queue_if bus();

  port_b_write_queue #(.DEPTH(4), .ADDR_BASE(8'h40)) dut (
    .clk(clk), .reset(reset), .bus(bus), .count(count),
    .overflow(overflow), .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic v; logic [7:0] a; logic [15:0] d; logic rdy; logic clr;
    logic e_inr; logic e_ov; logic chkh; logic [7:0] e_addr; logic [15:0] e_data;
    logic [2:0] e_cnt; logic e_ovf; logic [7:0] e_drop;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] a,
                              input logic [15:0] d, input logic rdy, input logic clr,
                              input logic inr, input logic ov, input logic chkh,
                              input logic [7:0] ea, input logic [15:0] ed,
                              input logic [2:0] ec, input logic eo, input logic [7:0] edr);
    vec_t r;
    r.rst = rst; r.v = v; r.a = a; r.d = d; r.rdy = rdy; r.clr = clr;
    r.e_inr = inr; r.e_ov = ov; r.chkh = chkh; r.e_addr = ea; r.e_data = ed;
    r.e_cnt = ec; r.e_ovf = eo; r.e_drop = edr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then idle inputs before sampling.
  task automatic step(input logic rst, input logic v, input logic [7:0] a,
                      input logic [15:0] d, input logic rdy, input logic clr);
    reset = rst; bus.in_valid = v; bus.in_addr = a; bus.in_data = d;
    bus.out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.in_valid = 1'b0; bus.in_addr = 8'h00; bus.in_data = 16'h0000;
    bus.out_ready = 1'b0; clr_overflow = 1'b0;
    #1;
  endtask

  initial begin
    logic [15:0] dv;
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_addr = 8'h00; bus.in_data = 16'h0000;
    bus.out_ready = 1'b0; clr_overflow = 1'b0;

    //               rst   v     addr   data      rdy   clr  | inr  ov   chkh addr   data      cnt   ovf   drop
    tbl[0]  = mk(1'b1, 1'b1, 8'h50, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 3'd0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b1, 1'b1, 8'h50, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 3'd0, 1'b0, 8'h00);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 3'd0, 1'b0, 8'h00);
    tbl[3]  = mk(1'b0, 1'b1, 8'h40, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd1, 1'b0, 8'h00);
    tbl[4]  = mk(1'b0, 1'b1, 8'h41, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd2, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b1, 8'h42, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd3, 1'b0, 8'h00);
    tbl[6]  = mk(1'b0, 1'b1, 8'h43, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd4, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b1, 8'h60, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd4, 1'b1, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd4, 1'b0, 8'h00);
    tbl[9]  = mk(1'b0, 1'b1, 8'h61, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd4, 1'b1, 8'h00);
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0001, 3'd4, 1'b0, 8'h00);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 16'h0002, 3'd3, 1'b0, 8'h00);
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 16'h0003, 3'd2, 1'b0, 8'h00);
    tbl[13] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h43, 16'h0004, 3'd1, 1'b0, 8'h00);
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b0, 8'h00);
    tbl[15] = mk(1'b0, 1'b1, 8'h44, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 16'h0005, 3'd1, 1'b0, 8'h00);
    tbl[16] = mk(1'b0, 1'b1, 8'h45, 16'h0006, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45, 16'h0006, 3'd1, 1'b0, 8'h00);
    tbl[17] = mk(1'b0, 1'b1, 8'h46, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45, 16'h0006, 3'd2, 1'b0, 8'h00);
    tbl[18] = mk(1'b0, 1'b1, 8'h47, 16'h0008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h46, 16'h0007, 3'd2, 1'b0, 8'h00);
    tbl[19] = mk(1'b0, 1'b1, 8'h00, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h46, 16'h0007, 3'd2, 1'b0, 8'h01);
    tbl[20] = mk(1'b0, 1'b1, 8'h3F, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h46, 16'h0007, 3'd2, 1'b0, 8'h02);

    #2;
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_inr));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
      if (tbl[i].chkh) begin
        chk($sformatf("vec%0d_out_addr", i), 32'(bus.out_addr), 32'(tbl[i].e_addr));
        chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
      end
    end

    // Pop while full with a beat arriving: pop happens, beat is overflow.
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'(8'h70 + k), 16'(16'h0A00 + k), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    step(1'b0, 1'b1, 8'h74, 16'h0A04, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_overflow", 32'(overflow), 32'd1);
    chk("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fullpop_head", 32'(bus.out_data), 32'h0A01);
    step(1'b0, 1'b1, 8'h75, 16'h0A05, 1'b0, 1'b0);
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_overflow_sticky", 32'(overflow), 32'd1);
    step(1'b1, 1'b1, 8'h76, 16'h0A06, 1'b0, 1'b0);
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_overflow", 32'(overflow), 32'd0);
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);

    // Continuous stream with the slave always ready.
    for (int i = 0; i < 16; i++) begin
      dv = 16'(16'h0100 + i);
`ifdef PORT_B_WQ_BYPASS_EN
      bus.in_valid = 1'b1; bus.in_addr = 8'(8'h40 + i); bus.in_data = dv; bus.out_ready = 1'b1;
      #1;
      chk($sformatf("bypass%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bypass%0d_out_data", i), 32'(bus.out_data), 32'(dv));
      step(1'b0, 1'b1, 8'(8'h40 + i), dv, 1'b1, 1'b0);
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd0);
`else
      step(1'b0, 1'b1, 8'(8'h40 + i), dv, 1'b1, 1'b0);
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d_addr", i), 32'(bus.out_addr), 32'(8'h40 + i));
      chk($sformatf("stream%0d_data", i), 32'(bus.out_data), 32'(dv));
`endif
      chk($sformatf("stream%0d_overflow", i), 32'(overflow), 32'd0);
    end
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    chk("stream_drain_count", 32'(count), 32'd0);

    // Filtering with drop counter saturation.
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 8'h3F, 16'(i), 1'b0, 1'b0);
      if (i == 2) chk("filter_drop_3", 32'(drop_cnt), 32'd3);
    end
    chk("filter_count", 32'(count), 32'd0);
    chk("filter_drop_sat", 32'(drop_cnt), 32'hFF);
    step(1'b0, 1'b1, 8'h40, 16'h7777, 1'b0, 1'b0);
    chk("base_accept_count", 32'(count), 32'd1);
    chk("base_accept_data", 32'(bus.out_data), 32'h7777);
    chk("base_drop_held", 32'(drop_cnt), 32'hFF);

    // Pointer wrap: offset pointers by one, then three push-4/pop-4 rounds.
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h90, 16'h0055, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'(8'h80 + k), 16'(r * 16 + k), 1'b0, 1'b0);
      chk($sformatf("wrap%0d_full", r), 32'(count), 32'd4);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("wrap%0d_data%0d", r, k), 32'(bus.out_data), 32'(r * 16 + k));
        chk($sformatf("wrap%0d_addr%0d", r, k), 32'(bus.out_addr), 32'(8'h80 + k));
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
      end
      chk($sformatf("wrap%0d_empty", r), 32'(count), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
